// File: rtl/draw_sequencer_if.sv
// draw_sequencer_if: start/done handshake, engine handshakes, engine pixel buses and vga plot port
// Modports:
//   slave  - the sequencer: takes start/skip_clear/clear_colour and engine outputs,
//            drives done/busy, engine starts, fill_colour and the vga plot port
//   master - the surrounding top level, engines and vga_adapter side
interface draw_sequencer_if;
    logic       start;
    logic       done;
    logic       busy;
    logic       skip_clear;
    logic [2:0] clear_colour;
    logic [2:0] fill_colour;
    logic       fill_start;
    logic       fill_done;
    logic [7:0] fill_x;
    logic [6:0] fill_y;
    logic [2:0] fill_c;
    logic       fill_plot;
    logic       shape_start;
    logic       shape_done;
    logic [7:0] shape_x;
    logic [6:0] shape_y;
    logic [2:0] shape_c;
    logic       shape_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport slave (
        input  start, skip_clear, clear_colour,
        input  fill_done, fill_x, fill_y, fill_c, fill_plot,
        input  shape_done, shape_x, shape_y, shape_c, shape_plot,
        output done, busy, fill_colour, fill_start, shape_start,
        output vga_x, vga_y, vga_colour, vga_plot
    );

    modport master (
        output start, skip_clear, clear_colour,
        output fill_done, fill_x, fill_y, fill_c, fill_plot,
        output shape_done, shape_x, shape_y, shape_c, shape_plot,
        input  done, busy, fill_colour, fill_start, shape_start,
        input  vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/draw_sequencer.sv
// draw_sequencer: runs a screen clear then one shape engine, and muxes the granted engine onto the vga plot port
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   io_bus - draw_sequencer_if.slave: start/done/busy handshake, fill and shape engine
//            start/done + pixel buses, vga_x/vga_y/vga_colour/vga_plot
// Build option: define DRAW_SEQ_CLIP_EN to suppress forwarded plots outside SCREEN_W x SCREEN_H.
module draw_sequencer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input logic              clk,
    input logic              rst_n,
    draw_sequencer_if.slave  io_bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, CLEAR_REL, DRAW, DRAW_REL, FINISH} state_t;

    // The screen must fit the 8-bit x / 7-bit y pixel buses.
    if (SCREEN_W > 256 || SCREEN_H > 128) begin : g_bad_size
        $error("draw_sequencer: screen size exceeds pixel bus width");
    end

    state_t     r_state;
    state_t     w_next;
    logic       r_fill_start;
    logic       r_shape_start;
    logic       r_done;
    logic       r_busy;
    logic       r_plot;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_c;
    logic [2:0] r_fill_colour;
    logic       w_fill_start;
    logic       w_shape_start;
    logic       w_done;
    logic       w_busy;
    logic       w_grant;
    logic       w_plot;
    logic [7:0] w_x;
    logic [6:0] w_y;
    logic [2:0] w_c;

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_fill_start  <= 1'b0;
            r_shape_start <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_plot        <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_c           <= '0;
            r_fill_colour <= '0;
        end else begin
            r_state       <= w_next;
            r_fill_start  <= w_fill_start;
            r_shape_start <= w_shape_start;
            r_done        <= w_done;
            r_busy        <= w_busy;
            r_plot        <= w_plot;
            if (w_grant) begin
                r_x <= w_x;
                r_y <= w_y;
                r_c <= w_c;
            end
            if (r_state == IDLE && io_bus.start)
                r_fill_colour <= io_bus.clear_colour;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (io_bus.start) w_next = io_bus.skip_clear ? DRAW : CLEAR;
            CLEAR:     if (io_bus.fill_done) w_next = CLEAR_REL;
            CLEAR_REL: if (!io_bus.fill_done) w_next = DRAW;
            DRAW:      if (io_bus.shape_done) w_next = DRAW_REL;
            DRAW_REL:  if (!io_bus.shape_done) w_next = FINISH;
            FINISH:    if (!io_bus.start) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // The grant follows the current registered state, so a plot issued in the
    // cycle an engine's start is being dropped is still forwarded.
    always_comb begin
        w_fill_start  = (w_next == CLEAR);
        w_shape_start = (w_next == DRAW);
        w_done        = (w_next == FINISH);
        w_busy        = (w_next != IDLE);
        w_grant       = (r_state == CLEAR) ? io_bus.fill_plot :
                        (r_state == DRAW)  ? io_bus.shape_plot : 1'b0;
        w_x           = (r_state == CLEAR) ? io_bus.fill_x : io_bus.shape_x;
        w_y           = (r_state == CLEAR) ? io_bus.fill_y : io_bus.shape_y;
        w_c           = (r_state == CLEAR) ? io_bus.fill_c : io_bus.shape_c;
`ifdef DRAW_SEQ_CLIP_EN
        w_plot        = w_grant && (32'(w_x) < 32'(SCREEN_W)) && (32'(w_y) < 32'(SCREEN_H));
`else
        w_plot        = w_grant;
`endif
    end

    assign io_bus.fill_start  = r_fill_start;
    assign io_bus.shape_start = r_shape_start;
    assign io_bus.done        = r_done;
    assign io_bus.busy        = r_busy;
    assign io_bus.fill_colour = r_fill_colour;
    assign io_bus.vga_x       = r_x;
    assign io_bus.vga_y       = r_y;
    assign io_bus.vga_colour  = r_c;
    assign io_bus.vga_plot    = r_plot;
endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: directed scoreboard bench for draw_sequencer with engine models driven inline
module tb_draw_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    typedef struct packed {
        logic       p;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t exp_q[$];
    pix_t last = '0;

    draw_sequencer_if bus ();

    draw_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, req);
        end
    endtask

    // One clock: drive engine pixel buses, predict the vga port one edge later, compare.
    task automatic cyc(input logic fp, input logic [7:0] fx, input logic [6:0] fy, input logic [2:0] fc,
                       input logic sp, input logic [7:0] sx, input logic [6:0] sy, input logic [2:0] sc);
        pix_t e;
        bus.fill_plot  = fp;
        bus.fill_x     = fx;
        bus.fill_y     = fy;
        bus.fill_c     = fc;
        bus.shape_plot = sp;
        bus.shape_x    = sx;
        bus.shape_y    = sy;
        bus.shape_c    = sc;
        e = last;
        e.p = 1'b0;
        if (bus.fill_start && fp) e = '{1'b1, fx, fy, fc};
        else if (bus.shape_start && sp) e = '{1'b1, sx, sy, sc};
`ifdef DRAW_SEQ_CLIP_EN
        if (e.p && (e.x >= 8'd160 || e.y >= 7'd120)) e.p = 1'b0;
`endif
        last = e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("vga_plot", bus.vga_plot, e.p);
        chk("vga_x", bus.vga_x, e.x);
        chk("vga_y", bus.vga_y, e.y);
        chk("vga_colour", bus.vga_colour, e.c);
    endtask

    task automatic idle();
        cyc(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 8'd0, 7'd0, 3'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.skip_clear = 1'b0;
        bus.clear_colour = 3'd0;
        bus.fill_done = 1'b0;
        bus.shape_done = 1'b0;
        bus.fill_plot = 1'b0;
        bus.fill_x = '0;
        bus.fill_y = '0;
        bus.fill_c = '0;
        bus.shape_plot = 1'b0;
        bus.shape_x = '0;
        bus.shape_y = '0;
        bus.shape_c = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fill_start", bus.fill_start, 0);
        chk("rst_shape_start", bus.shape_start, 0);
        chk("rst_vga_plot", bus.vga_plot, 0);
        chk("rst_vga_xyc", {bus.vga_x, bus.vga_y, bus.vga_colour}, 0);
        chk("rst_fill_colour", bus.fill_colour, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-CLEAR: asynchronous clear while fill plots stream
        bus.start = 1'b1;
        bus.clear_colour = 3'd6;
        idle();
        chk("mid_fill_start", bus.fill_start, 1);
        for (int i = 1; i < 5; i++) cyc(1'b1, 8'(i), 7'(i), 3'd6, 1'b0, 8'd0, 7'd0, 3'd0);
        bus.fill_plot = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_fill_start", bus.fill_start, 0);
        chk("arst_vga_plot", bus.vga_plot, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_vga_x", bus.vga_x, 0);
        chk("arst_fill_colour", bus.fill_colour, 0);
        bus.start = 1'b0;
        bus.fill_plot = 1'b0;
        exp_q.delete();
        last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full sequence: clear with 19200 plots, then 500 shape plots
        bus.start = 1'b1;
        bus.clear_colour = 3'b010;
        bus.skip_clear = 1'b0;
        idle();
        chk("full_fill_start", bus.fill_start, 1);
        chk("full_shape_start", bus.shape_start, 0);
        chk("full_fill_colour", bus.fill_colour, 3'b010);
        chk("full_busy", bus.busy, 1);
        cyc(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 8'd10, 7'd10, 3'd7);
        for (int n = 0; n < 19200; n++)
            cyc(1'b1, 8'(n % 160), 7'(n / 160), 3'b010, n < 20, 8'd10, 7'd10, 3'd7);
        bus.fill_done = 1'b1;
        idle();
        for (int i = 0; i < 8 && bus.fill_start; i++) idle();
        chk("fill_start_rel", bus.fill_start, 0);
        chk("clear_rel_shape_start", bus.shape_start, 0);
        bus.fill_done = 1'b0;
        idle();
        chk("draw_shape_start", bus.shape_start, 1);
        chk("draw_fill_start", bus.fill_start, 0);
        for (int k = 0; k < 500; k++)
            cyc(k % 50 == 0, 8'd1, 7'd1, 3'd1, 1'b1, 8'((k * 7) % 160), 7'((k * 3) % 120), 3'(k));
        bus.shape_done = 1'b1;
        idle();
        for (int i = 0; i < 8 && bus.shape_start; i++) idle();
        chk("shape_start_rel", bus.shape_start, 0);
        chk("done_before_release", bus.done, 0);
        bus.shape_done = 1'b0;
        idle();
        chk("full_done", bus.done, 1);
        chk("full_done_busy", bus.busy, 1);

        // Handshake hold: done persists while start is held
        for (int i = 0; i < 50; i++) begin
            idle();
            chk("hold_done", bus.done, 1);
            chk("hold_no_restart", {bus.fill_start, bus.shape_start}, 0);
        end
        bus.start = 1'b0;
        idle();
        chk("drop_done", bus.done, 0);
        chk("drop_busy", bus.busy, 0);

        // Skip clear, start dropped mid-sequence, clip boundaries
        bus.skip_clear = 1'b1;
        bus.clear_colour = 3'd5;
        bus.start = 1'b1;
        idle();
        chk("skip_shape_start", bus.shape_start, 1);
        chk("skip_fill_start", bus.fill_start, 0);
        chk("skip_fill_colour", bus.fill_colour, 3'd5);
        bus.start = 1'b0;
        bus.skip_clear = 1'b0;
        cyc(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 8'd159, 7'd119, 3'd3);
        cyc(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 8'd160, 7'd5, 3'd4);
        cyc(1'b1, 8'd9, 7'd9, 3'd2, 1'b1, 8'd3, 7'd120, 3'd5);
        idle();
        chk("skip_no_fill", bus.fill_start, 0);
        bus.shape_done = 1'b1;
        idle();
        chk("skip_rel_done", bus.done, 0);
        bus.shape_done = 1'b0;
        idle();
        chk("short_done_hi", bus.done, 1);
        idle();
        chk("short_done_lo", bus.done, 0);
        chk("short_busy_lo", bus.busy, 0);
        idle();
        chk("idle_stays", bus.busy, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Sequences the two drawing engines of the 160x120 VGA path: a screen clear (fillscreen engine), then one shape engine (circle/triangle drawer).
- Owns the single vga_adapter plot port and muxes the active engine's x/y/colour/plot onto it.
- Sits between the board top level (KEY/SW) and the engines + vga_adapter.
- Provides one start/done handshake to the top level.

Parameters:
- SCREEN_W, 160, pixel columns; plots with x >= SCREEN_W are suppressed.
- SCREEN_H, 120, pixel rows; plots with y >= SCREEN_H are suppressed.

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level request from top; sequence runs while held
- done  out  1  sequence complete; held until start drops
- busy  out  1  high in any state other than IDLE
- skip_clear  in  1  sampled on IDLE->run; 1 = skip the clear phase
- clear_colour  in  3  sampled on IDLE->run; driven to fill engine
- fill_colour  out  3  latched clear_colour
- fill_start  out  1  fill engine start
- fill_done  in  1  fill engine done
- fill_x / fill_y / fill_c / fill_plot  in  8/7/3/1  fill engine pixel output
- shape_start  out  1  shape engine start
- shape_done  in  1  shape engine done
- shape_x / shape_y / shape_c / shape_plot  in  8/7/3/1  shape engine pixel output
- vga_x / vga_y / vga_colour / vga_plot  out  8/7/3/1  to vga_adapter

Behaviour:
- Engine protocol:
  - Engine start is level-held.
  - Engine raises done and holds it until its start drops, then clears done.
- FSM states: IDLE, CLEAR, CLEAR_REL, DRAW, DRAW_REL, FINISH.
  - IDLE: on start=1, latch skip_clear and clear_colour; go to CLEAR (skip_clear=0) or DRAW (skip_clear=1).
  - CLEAR: fill_start=1. On fill_done=1 -> CLEAR_REL.
  - CLEAR_REL: fill_start=0. Wait for fill_done=0 -> DRAW.
  - DRAW: shape_start=1. On shape_done=1 -> DRAW_REL.
  - DRAW_REL: shape_start=0. Wait for shape_done=0 -> FINISH.
  - FINISH: done=1. On start=0 -> IDLE, and done drops the same edge.
- fill_start and shape_start are registered and never high simultaneously.
- start dropping mid-sequence:
  - Ignored; the sequence runs to FINISH.
  - done asserts for exactly 1 cycle when start is already 0, then the FSM returns to IDLE.
- Plot mux:
  - Source is the fill inputs in CLEAR, the shape inputs in DRAW, and none in all other states.
  - Outputs are registered, 1-cycle latency: engine plot at cycle N appears on vga_* at N+1.
  - In a non-plotting state, vga_plot=0 and x/y/colour hold their last values.
  - A plot whose start is dropping in that cycle is still forwarded: the mux select is the registered state at cycle N.
- Engine plots while not granted (e.g. shape_plot during CLEAR) are dropped silently.
- Reset, asynchronous, any state:
  - State returns to IDLE.
  - done, busy, fill_start, shape_start, vga_plot = 0.
  - vga_x=0, vga_y=0, vga_colour=0, fill_colour=0.
- Widths: x/y compared unsigned against SCREEN_W/SCREEN_H at full port width.

Optional Feature:
- Macro DRAW_SEQ_CLIP_EN.
- Defined:
  - Forwarded plots with x >= SCREEN_W or y >= SCREEN_H drive vga_plot=0 for that cycle.
  - x/y/colour still update.
- Undefined:
  - No bounds check; every granted plot is forwarded (vga_adapter discards off-screen writes).

Test Plan:
- Reset mid-CLEAR:
  - Stimulus: start=1, skip_clear=0; fill_plot pulses; assert rst_n=0 on cycle 5.
  - Required: fill_start=0, vga_plot=0, busy=0 immediately (asynchronous).
- Full sequence:
  - Stimulus: start=1, clear_colour=3'b010, skip_clear=0; model fill done after 19200 plots, shape done after 500 plots.
  - Required:
    - fill_colour=3'b010.
    - 19200 fill plots forwarded, then 500 shape plots, each delayed 1 cycle.
    - done=1 only after shape_done drops.
- Skip clear:
  - Stimulus: skip_clear=1, start=1.
  - Required: fill_start never asserts; shape_start=1 one cycle after start is sampled.
- Handshake hold:
  - Stimulus: hold start=1 for 50 cycles after done.
  - Required: done stays 1, no engine restarts. Drop start: done=0 and busy=0 next edge.
- Cross-grant isolation:
  - Stimulus: shape_plot=1 with x=10, y=10 during CLEAR.
  - Required: no vga_plot from the shape source; fill plots are unaffected.
- Clip, DRAW_SEQ_CLIP_EN defined:
  - Stimulus: shape plots x=159 y=119, then x=160 y=5, then x=3 y=120.
  - Required: vga_plot = 1, 0, 0 on successive output cycles; without the macro all three are 1.
